svc_rv_mem_arb: RTL and testbench

SVC_RV_MEM_ARB -- requirements
Module: svc_rv_mem_arb

---
 rtl/svc_rv_mem_arb.sv | 113 +++++++++++
 tb/tb_svc_rv_mem_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_mem_arb.sv
// Two-requester arbiter onto a single-ported SRAM with one-cycle read latency.
// Build option: SVC_RV_MEM_ARB_FIXED_PRIO_EN gives m0 strict priority instead of round-robin.
module svc_rv_mem_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic              m0_write,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    input  logic [DW/8-1:0]   m0_wstrb,
    output logic              m0_rvalid,
    output logic [DW-1:0]     m0_rdata,

    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic              m1_write,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    input  logic [DW/8-1:0]   m1_wstrb,
    output logic              m1_rvalid,
    output logic [DW-1:0]     m1_rdata,

    output logic [AW-1:0]     mem_raddr,
    input  logic [DW-1:0]     mem_rdata,
    output logic              mem_wen,
    output logic [AW-1:0]     mem_waddr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wstrb
);

    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              rd_gnt;
    logic              sel_write;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic [DW/8-1:0]   sel_wstrb;
    logic              pend;
    logic              owner;

`ifndef SVC_RV_MEM_ARB_FIXED_PRIO_EN
    logic              ptr;  // 0: m0 wins next contention, 1: m1 wins
`endif

    // Grants are suppressed while reset is asserted so nothing reaches the SRAM.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
`ifdef SVC_RV_MEM_ARB_FIXED_PRIO_EN
            gnt0 = m0_valid;
            gnt1 = m1_valid && !m0_valid;
`else
            if (m0_valid && m1_valid) begin
                gnt0 = !ptr;
                gnt1 = ptr;
            end else begin
                gnt0 = m0_valid;
                gnt1 = m1_valid;
            end
`endif
        end
    end

    assign any_gnt   = gnt0 || gnt1;
    assign sel_write = gnt1 ? m1_write : m0_write;
    assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
    assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;
    assign sel_wstrb = gnt1 ? m1_wstrb : m0_wstrb;
    assign rd_gnt    = any_gnt && !sel_write;

    assign m0_ready  = gnt0;
    assign m1_ready  = gnt1;

    assign mem_wen   = any_gnt && sel_write;
    assign mem_waddr = mem_wen ? sel_addr  : '0;
    assign mem_wdata = mem_wen ? sel_wdata : '0;
    assign mem_wstrb = mem_wen ? sel_wstrb : '0;
    assign mem_raddr = rd_gnt  ? sel_addr  : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            owner <= 1'b0;
`ifndef SVC_RV_MEM_ARB_FIXED_PRIO_EN
            ptr   <= 1'b0;
`endif
        end else begin
            pend <= rd_gnt;
            if (rd_gnt) begin
                owner <= gnt1;
            end
`ifndef SVC_RV_MEM_ARB_FIXED_PRIO_EN
            // Any grant hands priority to the requester that was not served.
            if (any_gnt) begin
                ptr <= gnt0;
            end
`endif
        end
    end

    assign m0_rvalid = pend && !owner;
    assign m1_rvalid = pend && owner;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_svc_rv_mem_arb.sv
// Table-driven bench for svc_rv_mem_arb with a behavioural write-first SRAM model.
module tb_svc_rv_mem_arb;

`ifdef SVC_RV_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_valid, m0_ready, m0_write, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_ready, m1_write, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    svc_rv_mem_arb #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    // SRAM model: write lands before the same-edge read, read data appears next cycle.
    logic [31:0] mem_arr [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
        mem_arr[8'h04 >> 2] = 32'hA0A0_A004;
        mem_arr[8'h08 >> 2] = 32'hB0B0_B008;
        mem_arr[8'h20 >> 2] = 32'h1234_5678;
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem_arr[mem_waddr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
        mem_rdata <= mem_arr[mem_raddr[7:2]];
    end

    typedef struct {
        logic        v0, w0;
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        logic        v1, w1;
        logic [31:0] a1, d1;
        logic [3:0]  s1;
    } in_t;

    typedef struct {
        logic        r0, r1, wen;
        logic [31:0] raddr, waddr, wdata;
        logic [3:0]  wstrb;
        logic        rv0, rv1;
        logic [31:0] rd0, rd1;
    } ex_t;

    typedef struct {
        in_t in;
        ex_t ex;
    } vec_t;

    vec_t tbl [16];

    function automatic in_t mk_in(input logic v0, input logic w0, input logic [31:0] a0,
                                  input logic [31:0] d0, input logic [3:0] s0,
                                  input logic v1, input logic w1, input logic [31:0] a1,
                                  input logic [31:0] d1, input logic [3:0] s1);
        in_t t;
        t.v0 = v0; t.w0 = w0; t.a0 = a0; t.d0 = d0; t.s0 = s0;
        t.v1 = v1; t.w1 = w1; t.a1 = a1; t.d1 = d1; t.s1 = s1;
        return t;
    endfunction

    function automatic ex_t mk_ex(input logic r0, input logic r1, input logic wen,
                                  input logic [31:0] raddr, input logic [31:0] waddr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb,
                                  input logic rv0, input logic rv1,
                                  input logic [31:0] rd0, input logic [31:0] rd1);
        ex_t t;
        t.r0 = r0; t.r1 = r1; t.wen = wen; t.raddr = raddr; t.waddr = waddr;
        t.wdata = wdata; t.wstrb = wstrb; t.rv0 = rv0; t.rv1 = rv1; t.rd0 = rd0; t.rd1 = rd1;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t t);
        m0_valid = t.v0; m0_write = t.w0; m0_addr = t.a0; m0_wdata = t.d0; m0_wstrb = t.s0;
        m1_valid = t.v1; m1_write = t.w1; m1_addr = t.a1; m1_wdata = t.d1; m1_wstrb = t.s1;
    endtask

    in_t idle_in;
    ex_t idle_ex;

    initial begin
        idle_in = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_ex = mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tbl[i].in = idle_in;
            tbl[i].ex = idle_ex;
        end
        tbl[3].in  = mk_in(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0);
        tbl[3].ex  = mk_ex(1, 0, 1, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
        tbl[4].in  = mk_in(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 0);
        tbl[4].ex  = mk_ex(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        tbl[5].ex  = mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        tbl[6].in  = mk_in(1, 1, 32'h20, 32'h0000_AAAA, 4'h3, 0, 0, 0, 0, 0);
        tbl[6].ex  = mk_ex(1, 0, 1, 0, 32'h20, 32'h0000_AAAA, 4'h3, 0, 0, 0, 0);
        tbl[7].in  = mk_in(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        tbl[7].ex  = mk_ex(1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        tbl[8].ex  = mk_ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234_AAAA, 0);
        tbl[9].in  = mk_in(0, 0, 0, 0, 0, 1, 0, 32'h08, 0, 0);
        tbl[9].ex  = mk_ex(0, 1, 0, 32'h08, 0, 0, 0, 0, 0, 0, 0);
        tbl[10].ex = mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hB0B0_B008);
        // Four cycles of contended reads; pointer points at m0 going in.
        for (int k = 0; k < 4; k++) begin
            logic g1;
            g1 = !FIXED && (k % 2 == 1);
            tbl[11+k].in     = mk_in(1, 0, 32'h04, 0, 0, 1, 0, 32'h08, 0, 0);
            tbl[11+k].ex.r0  = !g1;
            tbl[11+k].ex.r1  = g1;
            tbl[11+k].ex.raddr = g1 ? 32'h08 : 32'h04;
            tbl[12+k].ex.rv0 = !g1;
            tbl[12+k].ex.rv1 = g1;
            tbl[12+k].ex.rd0 = g1 ? 32'h0 : 32'hA0A0_A004;
            tbl[12+k].ex.rd1 = g1 ? 32'hB0B0_B008 : 32'h0;
        end

        // Reset with a write request pending: nothing may be granted.
        rst_n = 1'b0;
        drive(mk_in(1, 1, 32'h30, 32'h5555_5555, 4'hF, 1, 0, 32'h04, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst m0_ready", {31'b0, m0_ready}, 0);
        chk("rst m1_ready", {31'b0, m1_ready}, 0);
        chk("rst mem_wen", {31'b0, mem_wen}, 0);
        chk("rst m0_rvalid", {31'b0, m0_rvalid}, 0);
        chk("rst m1_rvalid", {31'b0, m1_rvalid}, 0);
        drive(idle_in);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 drive(tbl[i].in);
            @(negedge clk);
            chk($sformatf("row%0d m0_ready", i), {31'b0, m0_ready}, {31'b0, tbl[i].ex.r0});
            chk($sformatf("row%0d m1_ready", i), {31'b0, m1_ready}, {31'b0, tbl[i].ex.r1});
            chk($sformatf("row%0d mem_wen", i), {31'b0, mem_wen}, {31'b0, tbl[i].ex.wen});
            chk($sformatf("row%0d mem_raddr", i), mem_raddr, tbl[i].ex.raddr);
            chk($sformatf("row%0d mem_waddr", i), mem_waddr, tbl[i].ex.waddr);
            chk($sformatf("row%0d mem_wdata", i), mem_wdata, tbl[i].ex.wdata);
            chk($sformatf("row%0d mem_wstrb", i), {28'b0, mem_wstrb}, {28'b0, tbl[i].ex.wstrb});
            chk($sformatf("row%0d m0_rvalid", i), {31'b0, m0_rvalid}, {31'b0, tbl[i].ex.rv0});
            chk($sformatf("row%0d m1_rvalid", i), {31'b0, m1_rvalid}, {31'b0, tbl[i].ex.rv1});
            chk($sformatf("row%0d m0_rdata", i), m0_rdata, tbl[i].ex.rd0);
            chk($sformatf("row%0d m1_rdata", i), m1_rdata, tbl[i].ex.rd1);
        end

        // Read granted to m1, then reset sampled at the following edge.
        @(posedge clk);
        #1 drive(mk_in(0, 0, 0, 0, 0, 1, 0, 32'h08, 0, 0));
        @(negedge clk);
        chk("mrst m1_ready", {31'b0, m1_ready}, 1);
        chk("mrst mem_raddr", mem_raddr, 32'h08);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 drive(idle_in);
        @(negedge clk);
        chk("mrst m1_rvalid c1", {31'b0, m1_rvalid}, 0);
        chk("mrst m1_rdata c1", m1_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mrst m1_rvalid c2", {31'b0, m1_rvalid}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 drive(mk_in(1, 0, 32'h04, 0, 0, 1, 0, 32'h08, 0, 0));
        @(negedge clk);
        chk("post-rst m0_ready", {31'b0, m0_ready}, 1);
        chk("post-rst m1_ready", {31'b0, m1_ready}, 0);
        chk("post-rst m1_rvalid", {31'b0, m1_rvalid}, 0);
        @(posedge clk);
        #1 drive(idle_in);
        @(negedge clk);
        chk("post-rst m0_rvalid", {31'b0, m0_rvalid}, 1);
        chk("post-rst m0_rdata", m0_rdata, 32'hA0A0_A004);
        chk("post-rst m1_rvalid2", {31'b0, m1_rvalid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
